// File: rtl/gerador_minas.sv
// Minesweeper board generator.
// Clears an internal mine map, scatters mines with a 16-bit LFSR while keeping
// the 3x3 area around the first-click cell free, and then streams every cell
// word (mine bit, revealed bit, neighbour count) to an external cell buffer in
// raster order.
module gerador_minas (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  altura,
  input  logic [9:0]  largura,
  input  logic [9:0]  num_minas,
  input  logic [5:0]  safe_lin,
  input  logic [5:0]  safe_col,
  input  logic [15:0] seed,
  output logic [9:0]  write_addr,
  output logic [5:0]  y_in,
  output logic        write_enable,
  output logic        done_minas,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_PLACE, S_WRITE, S_DONE} state_t;

  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  state_t        state_q, state_d;

  logic [10:0]   tam_q, tam_d;
  logic [9:0]    nmin_q, nmin_d;
  logic [9:0]    placed_q, placed_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [10:0]   clr_q, clr_d;
  logic [5:0]    lin_q, lin_d;
  logic [5:0]    col_q, col_d;
  logic [1023:0] map_q;
  logic          map_clr, map_set;

  logic [9:0]    addr_q, addr_d;
  logic [5:0]    y_q, y_d;
  logic          we_q, we_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  // ---------------------------------------------------------------------------
  // Board size and mine count clamp (at most tam-9 so the safe window fits)
  // ---------------------------------------------------------------------------
  logic [10:0] alt_ext, larg_ext, tam_calc, tam_m9;
  assign alt_ext  = {1'b0, altura};
  assign larg_ext = {1'b0, largura};
  assign tam_calc = alt_ext * larg_ext;
  assign tam_m9   = tam_calc - 11'd9;

  // ---------------------------------------------------------------------------
  // LFSR and candidate cell
  // ---------------------------------------------------------------------------
  logic [15:0] lfsr_next;
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  logic [5:0] cand_lin, cand_col;
  logic [9:0] cand_addr;
  logic       cand_in_board, cand_in_window, cand_ok;
  assign cand_lin  = lfsr_q[5:0];
  assign cand_col  = lfsr_q[11:6];
  assign cand_addr = {4'd0, cand_lin} * largura + {4'd0, cand_col};

  assign cand_in_board  = ({4'd0, cand_lin} < altura) && ({4'd0, cand_col} < largura);
  // |cand - safe| <= 1 in both axes, written without signed arithmetic
  assign cand_in_window = ({1'b0, cand_lin} + 7'd1 >= {1'b0, safe_lin}) &&
                          ({1'b0, cand_lin} <= {1'b0, safe_lin} + 7'd1) &&
                          ({1'b0, cand_col} + 7'd1 >= {1'b0, safe_col}) &&
                          ({1'b0, cand_col} <= {1'b0, safe_col} + 7'd1);
  assign cand_ok = cand_in_board && !cand_in_window && !map_q[cand_addr];

  // ---------------------------------------------------------------------------
  // Write-phase cell and its eight neighbours
  // ---------------------------------------------------------------------------
  logic [9:0] base;
  logic [9:0] a_ul, a_u, a_ur, a_l, a_r, a_dl, a_d, a_dr;
  logic       has_u, has_d, has_l, has_r;
  logic [7:0] nb;
  logic [3:0] nb_sum;
  logic [2:0] nb_cnt;
  logic       is_safe;

  assign base  = {4'd0, lin_q} * largura + {4'd0, col_q};
  assign a_u   = base - largura;
  assign a_ul  = a_u - 10'd1;
  assign a_ur  = a_u + 10'd1;
  assign a_l   = base - 10'd1;
  assign a_r   = base + 10'd1;
  assign a_d   = base + largura;
  assign a_dl  = a_d - 10'd1;
  assign a_dr  = a_d + 10'd1;

  // Off-board neighbours are masked so edges and corners count them as empty
  assign has_u = (lin_q != 6'd0);
  assign has_l = (col_q != 6'd0);
  assign has_d = ({4'd0, lin_q} + 10'd1) < altura;
  assign has_r = ({4'd0, col_q} + 10'd1) < largura;

  assign nb = {has_u & has_l & map_q[a_ul], has_u & map_q[a_u], has_u & has_r & map_q[a_ur],
               has_l & map_q[a_l], has_r & map_q[a_r],
               has_d & has_l & map_q[a_dl], has_d & map_q[a_d], has_d & has_r & map_q[a_dr]};

  // Population count of the neighbour mines
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so each step sees the previous one; flops use '<='.
    nb_sum = 4'd0;
    for (int i = 0; i < 8; i++) nb_sum = nb_sum + {3'd0, nb[i]};
  end

  // Eight mines do not fit in three bits; they saturate to seven
  assign nb_cnt  = nb_sum[3] ? 3'd7 : nb_sum[2:0];
  assign is_safe = (lin_q == safe_lin) && (col_q == safe_col);

  logic last_clear, place_done, last_col, last_cell;
  assign last_clear = (clr_q == tam_q - 11'd1);
  assign place_done = (placed_q == nmin_q);
  assign last_col   = ({4'd0, col_q} == largura - 10'd1);
  assign last_cell  = last_col && ({4'd0, lin_q} == altura - 10'd1);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every path assigns state_d via this default, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)      state_d = S_CLEAR;
      S_CLEAR: if (last_clear) state_d = S_PLACE;
      S_PLACE: if (place_done) state_d = S_WRITE;
      S_WRITE: if (last_cell)  state_d = S_DONE;
      S_DONE:                  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Output logic; results are registered, so the pins trail the state by one cycle
  always_comb begin
    we_d   = 1'b0;
    addr_d = 10'd0;
    y_d    = 6'd0;
    done_d = (state_q == S_DONE);
    busy_d = (state_q != S_IDLE);
    if (state_q == S_WRITE) begin
      we_d   = 1'b1;
      addr_d = base;
      y_d    = {1'b0, map_q[base], is_safe, nb_cnt};
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // Next values of counters, LFSR and map update strobes
  always_comb begin
    tam_d    = tam_q;
    nmin_d   = nmin_q;
    placed_d = placed_q;
    lfsr_d   = lfsr_q;
    clr_d    = clr_q;
    lin_d    = lin_q;
    col_d    = col_q;
    map_clr  = 1'b0;
    map_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          tam_d    = tam_calc;
          nmin_d   = ({1'b0, num_minas} < tam_m9) ? num_minas : tam_m9[9:0];
          lfsr_d   = (seed == 16'd0) ? LFSR_DEFAULT : seed;
          placed_d = 10'd0;
          clr_d    = 11'd0;
          lin_d    = 6'd0;
          col_d    = 6'd0;
        end
      end
      S_CLEAR: begin
        map_clr = 1'b1;
        clr_d   = clr_q + 11'd1;
      end
      S_PLACE: begin
        lfsr_d = lfsr_next;
        if (!place_done && cand_ok) begin
          map_set  = 1'b1;
          placed_d = placed_q + 10'd1;
        end
      end
      S_WRITE: begin
        if (last_col) begin
          col_d = 6'd0;
          lin_d = lin_q + 6'd1;
        end else begin
          col_d = col_q + 6'd1;
        end
      end
      default: ;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential blocks use non-blocking '<=' so all flops update from pre-edge values.
      tam_q    <= 11'd0;
      nmin_q   <= 10'd0;
      placed_q <= 10'd0;
      lfsr_q   <= LFSR_DEFAULT;
      clr_q    <= 11'd0;
      lin_q    <= 6'd0;
      col_q    <= 6'd0;
    end else begin
      tam_q    <= tam_d;
      nmin_q   <= nmin_d;
      placed_q <= placed_d;
      lfsr_q   <= lfsr_d;
      clr_q    <= clr_d;
      lin_q    <= lin_d;
      col_q    <= col_d;
    end
  end

  // Mine map: cleared bit by bit in CLEAR, set on accepted candidates
  always_ff @(posedge clk) begin
    // NOTE: the map has no reset; CLEAR wipes every used address before it is read.
    if (map_clr)      map_q[clr_q[9:0]] <= 1'b0;
    else if (map_set) map_q[cand_addr]  <= 1'b1;
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= 10'd0;
      y_q    <= 6'd0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      y_q    <= y_d;
      we_q   <= we_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign write_addr   = addr_q;
  assign y_in         = y_q;
  assign write_enable = we_q;
  assign done_minas   = done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_gerador_minas.sv
// Testbench for gerador_minas: directed and random boards compared against a
// behavioural board model (LFSR walk + 2-D mine grid + neighbour counting).
module tb_gerador_minas;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  altura, largura, num_minas;
  logic [5:0]  safe_lin, safe_col;
  logic [15:0] seed;
  logic [9:0]  write_addr;
  logic [5:0]  y_in;
  logic        write_enable, done_minas, busy;

  always #5 clk = ~clk;

  gerador_minas dut (
    .clk(clk), .reset(reset), .start(start),
    .altura(altura), .largura(largura), .num_minas(num_minas),
    .safe_lin(safe_lin), .safe_col(safe_col), .seed(seed),
    .write_addr(write_addr), .y_in(y_in), .write_enable(write_enable),
    .done_minas(done_minas), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model results for the board under test
  int         m_tam, m_nmin, m_place;
  logic [5:0] m_y   [1024];
  int         m_cnt [1024];
  logic [5:0] obs_y [1024];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Generate the board from the rules: walk the LFSR, place mines in a grid,
  // then count neighbours of every cell.
  task automatic build_model(input int alt, input int lar, input int nm,
                             input int sl, input int sc, input logic [15:0] sd);
    bit          mine [64][64];
    logic [15:0] l;
    int          placed, r, c, cnt;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++) mine[i][j] = 1'b0;
    m_tam   = alt * lar;
    m_nmin  = (nm < m_tam - 9) ? nm : m_tam - 9;
    l       = (sd == 16'd0) ? 16'hACE1 : sd;
    placed  = 0;
    m_place = 0;
    while (m_place < 1000000) begin
      m_place++;
      if (placed == m_nmin) break;
      r = int'(l[5:0]);
      c = int'(l[11:6]);
      if (r < alt && c < lar && !mine[r][c] &&
          !(r >= sl - 1 && r <= sl + 1 && c >= sc - 1 && c <= sc + 1)) begin
        mine[r][c] = 1'b1;
        placed++;
      end
      l = lfsr_step(l);
    end
    for (int i = 0; i < alt; i++)
      for (int j = 0; j < lar; j++) begin
        cnt = 0;
        for (int di = -1; di <= 1; di++)
          for (int dj = -1; dj <= 1; dj++)
            if (!(di == 0 && dj == 0) && i + di >= 0 && i + di < alt &&
                j + dj >= 0 && j + dj < lar && mine[i + di][j + dj])
              cnt++;
        m_cnt[i * lar + j] = cnt;
        m_y[i * lar + j]   = {1'b0, mine[i][j], (i == sl && j == sc), (cnt > 7) ? 3'd7 : 3'(cnt)};
      end
  endtask

  // One generation: optional start spamming while busy, optional reset abort
  // (1 = mid-PLACE, 2 = mid-WRITE).
  task automatic run_board(input string tag, input int alt, input int lar, input int nm,
                           input int sl, input int sc, input logic [15:0] sd,
                           input bit spam, input int abort_mode);
    int cyc, widx, ndone, lat, abort_at, nmines;
    build_model(alt, lar, nm, sl, sc, sd);
    lat      = 2 * m_tam + m_place + 2;
    abort_at = (abort_mode == 1) ? m_tam + 2 + m_place / 2 :
               (abort_mode == 2) ? m_tam + m_place + 2 + m_tam / 2 : -1;
    for (int i = 0; i < 1024; i++) obs_y[i] = 6'h3F;
    altura    = 10'(alt);
    largura   = 10'(lar);
    num_minas = 10'(nm);
    safe_lin  = 6'(sl);
    safe_col  = 6'(sc);
    seed      = sd;
    @(negedge clk);
    start  = 1'b1;
    cyc    = 0;
    widx   = 0;
    ndone  = 0;
    nmines = 0;
    while (cyc < lat + 4) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = spam && (cyc < lat - 2) && (cyc % 5 == 2);
      if (write_enable) begin
        check({tag, ":done_with_we"}, 32'(done_minas), 32'd0);
        if (widx < m_tam) begin
          check({tag, ":addr"}, 32'(write_addr), 32'(widx));
          check({tag, ":cell"}, 32'(y_in), 32'(m_y[widx]));
          obs_y[widx] = y_in;
          nmines += int'(y_in[4]);
        end else begin
          check({tag, ":extra_write"}, 32'(write_enable), 32'd0);
        end
        widx++;
      end
      if (done_minas) begin
        ndone++;
        check({tag, ":latency"}, 32'(cyc), 32'(lat));
        check({tag, ":nwrites"}, 32'(widx), 32'(m_tam));
      end
      if (cyc == abort_at) begin
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        check({tag, ":rst_we"},   32'(write_enable), 32'd0);
        check({tag, ":rst_done"}, 32'(done_minas),   32'd0);
        check({tag, ":rst_busy"}, 32'(busy),         32'd0);
        check({tag, ":rst_addr"}, 32'(write_addr),   32'd0);
        check({tag, ":rst_y"},    32'(y_in),         32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check({tag, ":post_rst_idle"}, {29'd0, busy, write_enable, done_minas}, 32'd0);
        end
        return;
      end
    end
    check({tag, ":ndone"},    32'(ndone),  32'd1);
    check({tag, ":nmines"},   32'(nmines), 32'(m_nmin));
    check({tag, ":busy_end"}, 32'(busy),   32'd0);
  endtask

  initial begin
    int a, b, sat_idx, sat_seed, nwin;
    reset = 1'b1; start = 1'b0;
    altura = 10'd4; largura = 10'd4; num_minas = 10'd0;
    safe_lin = 6'd0; safe_col = 6'd0; seed = 16'd0;

    // Reset state
    @(negedge clk);
    check("reset:we",   32'(write_enable), 32'd0);
    check("reset:done", 32'(done_minas),   32'd0);
    check("reset:busy", 32'(busy),         32'd0);
    check("reset:addr", 32'(write_addr),   32'd0);
    check("reset:y",    32'(y_in),         32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("idle_no_start", {29'd0, busy, write_enable, done_minas}, 32'd0);
    end

    // 4x4, no mines, safe corner
    run_board("empty4x4", 4, 4, 0, 0, 0, 16'h5A5A, 1'b0, 0);
    check("empty4x4:safe_word", 32'(obs_y[0]), 32'h08);

    // 3x3 clamps mine count to zero
    run_board("clamp3x3", 3, 3, 5, 1, 1, 16'h0F0F, 1'b0, 0);
    check("clamp3x3:safe_word", 32'(obs_y[4]), 32'h08);

    // 8x8, 10 mines, fixed seed; window around safe cell mine-free
    run_board("b8x8", 8, 8, 10, 3, 4, 16'h1234, 1'b0, 0);
    nwin = 0;
    for (int r = 2; r <= 4; r++)
      for (int c = 3; c <= 5; c++) nwin += int'(obs_y[r * 8 + c][4]);
    check("b8x8:window_mines", 32'(nwin), 32'd0);

    // Saturation: find a dense 5x5 board holding a free cell ringed by 8 mines
    sat_idx = -1; sat_seed = 0;
    for (int s = 1; s < 4000 && sat_idx < 0; s++) begin
      build_model(5, 5, 16, 0, 0, 16'(s));
      for (int k = 0; k < 25; k++)
        if (sat_idx < 0 && m_cnt[k] == 8 && m_y[k][4] == 1'b0) begin
          sat_idx = k; sat_seed = s;
        end
    end
    if (sat_idx >= 0) begin
      run_board("sat5x5", 5, 5, 16, 0, 0, 16'(sat_seed), 1'b0, 0);
      check("sat5x5:count7", 32'(obs_y[sat_idx][2:0]), 32'd7);
    end else begin
      n_err++;
      $display("FAIL sat_search: no saturating board found");
    end

    // Reset mid-PLACE and mid-WRITE, then regenerate with the same seed
    run_board("abort_place", 8, 8, 10, 3, 4, 16'hBEEF, 1'b0, 1);
    run_board("abort_write", 8, 8, 10, 3, 4, 16'hBEEF, 1'b0, 2);
    run_board("restart",     8, 8, 10, 3, 4, 16'hBEEF, 1'b0, 0);

    // Start pulses while busy are ignored
    run_board("spam", 6, 7, 8, 5, 6, 16'hC001, 1'b1, 0);

    // Zero seed falls back to the default LFSR value; oversized mine request clamps
    run_board("seed0", 5, 6, 6, 2, 2, 16'h0000, 1'b0, 0);
    run_board("bigreq", 3, 4, 1000, 0, 3, 16'h7777, 1'b0, 0);

    // Random boards
    for (int t = 0; t < 4; t++) begin
      a = int'($urandom_range(3, 12));
      b = int'($urandom_range(3, 12));
      run_board("random", a, b, int'($urandom_range(0, (a * b) / 4)),
                int'($urandom_range(0, a - 1)), int'($urandom_range(0, b - 1)),
                16'($urandom), 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gerador_minas.md
GERADOR_MINAS -- requirements
Module: gerador_minas

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 start  in  1  one-cycle request to generate a board; sampled only in IDLE.
REQ-004 altura, largura  in  10 each  rows, columns; legal 3..64 each with altura*largura <= 1024; held stable while busy.
REQ-005 num_minas  in  10  requested mine count.
REQ-006 safe_lin, safe_col  in  6 each  first-click cell; must lie inside the board.
REQ-007 seed  in  16  LFSR seed; loaded on start.
REQ-008 write_addr  out  10  cell address, lin*largura+col.
REQ-009 y_in  out  6  cell word: bit5 flag, bit4 mine, bit3 revealed, bits2-0 neighbour count.
REQ-010 write_enable  out  1  write strobe to the cell buffer.
REQ-011 done_minas  out  1  one-cycle pulse: board complete.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 States: IDLE, CLEAR, PLACE, WRITE, DONE; all outputs registered.
REQ-014 IDLE->CLEAR on start; start outside IDLE is ignored.
REQ-015 On leaving IDLE: latch tam = altura*largura; nmin = min(num_minas, tam-9); LFSR <= seed, or 16'hACE1 if seed==0; placed count <= 0.
REQ-016 CLEAR: zero one bit per cycle of internal 1024-bit mine map over addresses 0..tam-1 (tam cycles), then PLACE.
REQ-017 LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances exactly once per PLACE cycle.
REQ-018 PLACE, one candidate per cycle: cand_lin = lfsr[5:0], cand_col = lfsr[11:6].
REQ-019 Candidate accepted iff cand_lin<altura, cand_col<largura, its map bit is 0, and it lies outside the 3x3 window centred on (safe_lin, safe_col); acceptance sets the map bit and increments placed count.
REQ-020 PLACE->WRITE when placed==nmin, checked before sampling a candidate; nmin==0 enters WRITE after one PLACE cycle.
REQ-021 WRITE: lin/col counters start at (0,0), raster order with column fastest; one cell per cycle; write_enable=1, write_addr=lin*largura+col.
REQ-022 No divider; the address comes only from the lin/col counters.
REQ-023 y_in[5]=0; y_in[4]=map bit.
REQ-024 y_in[3]=1 only for (safe_lin, safe_col), else 0.
REQ-025 y_in[2:0] = mines among the in-bounds 8 neighbours, saturated at 7 (8 encodes as 7).
REQ-026 Off-board neighbours count as 0 at edges and corners.
REQ-027 After the cell at tam-1: write_enable drops, state DONE.
REQ-028 DONE lasts one cycle with done_minas=1 and write_enable=0; done_minas never coincides with write_enable; then IDLE.
REQ-029 Total latency start->done_minas = 1 + tam + PLACE cycles + tam + 1.
REQ-030 The safe cell is always written as 6'b001000.

Reset
REQ-031 During reset: write_enable=0, done_minas=0, busy=0, write_addr=0, y_in=0, state=IDLE.
REQ-032 Reset mid-generation aborts with no further writes and no done_minas; the next start regenerates from scratch.
REQ-033 After reset release, nothing happens until start.

Verification
REQ-034 4x4, num_minas=0, safe=(0,0), start: 16 writes addr 0..15, all y_in=0 except addr0=6'b001000; done_minas 1 cycle after the last write.
REQ-035 3x3, num_minas=5, safe=(1,1): nmin clamps to 0; 9 writes, addr4=6'b001000.
REQ-036 8x8, num_minas=10, seed=16'h1234: exactly 10 bit4=1; none in 3x3 around safe; each bit2-0 matches a golden model.
REQ-037 Fixed 3x3 block of 8 mines around a non-mine centre: centre count saturates to 7.
REQ-038 Assert reset mid-PLACE and mid-WRITE: outputs zero immediately, no done_minas; a restart with the same seed gives an identical board.
REQ-039 start pulsed while busy: ignored; exactly one done_minas per accepted start.
